// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the FFT frame unloader
package fft_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        STREAM = 2'd1,
        DROP   = 2'd2
    } state_t;

    // Flag positions within the two marker bits stored above each sample
    localparam int FIRST_BIT = 1;
    localparam int LAST_BIT  = 0;

    localparam int STATS_W = 16;

endpackage

// File: rtl/fft_frame_unloader_if.sv
// rtl/fft_frame_unloader_if.sv - sample-in / valid-ready-out bundle of the unloader
interface fft_frame_unloader_if #(
    parameter int WIDTH = 24
);
    logic                 i_ce;
    logic [2*WIDTH-1:0]   i_sample;
    logic                 i_sync;
    logic                 o_valid;
    logic                 i_ready;
    logic [2*WIDTH-1:0]   o_data;
    logic                 o_first;
    logic                 o_last;

    modport master (
        output i_ce, i_sample, i_sync, i_ready,
        input  o_valid, o_data, o_first, o_last
    );

    modport slave (
        input  i_ce, i_sample, i_sync, i_ready,
        output o_valid, o_data, o_first, o_last
    );
endinterface

// File: rtl/fft_unload_fifo.sv
// rtl/fft_unload_fifo.sv - synchronous FIFO with occupancy count, combinational read port
module fft_unload_fifo #(
    parameter int DW     = 50,
    parameter int LGFIFO = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    output logic [DW-1:0]     rd_data,
    output logic [LGFIFO:0]   occ,
    output logic              empty
);
    localparam int DEPTH = 1 << LGFIFO;

    logic [DW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr;
    logic [LGFIFO-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign empty   = (occ == '0);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + LGFIFO'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + LGFIFO'(1);
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + (LGFIFO+1)'(1);
                2'b01:   occ <= occ - (LGFIFO+1)'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: rtl/fft_frame_unloader.sv
// rtl/fft_frame_unloader.sv - re-frames the FFT output into whole frames on a valid/ready stream
// Optional FFT_UNLOAD_STATS_EN adds saturating frame and drop counters.
module fft_frame_unloader
    import fft_pkg::*;
#(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24,
    parameter int LGFIFO = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    fft_frame_unloader_if.slave  s,
    output logic                 o_sync_err,
    output logic                 o_drop
`ifdef FFT_UNLOAD_STATS_EN
    ,
    output logic [STATS_W-1:0]   o_frame_count,
    output logic [STATS_W-1:0]   o_drop_count
`endif
);
    localparam int N     = 1 << LGSIZE;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int SW    = 2 * WIDTH;
    localparam int EW    = SW + 2;
    // free >= N is the same as occupancy <= DEPTH - N
    localparam logic [LGFIFO:0]   MAX_OCC  = (LGFIFO+1)'(DEPTH - N);
    localparam logic [LGSIZE-1:0] CNT_LAST = LGSIZE'(N - 1);
    localparam logic [1:0] S_SEARCH = SEARCH;
    localparam logic [1:0] S_STREAM = STREAM;
    localparam logic [1:0] S_DROP   = DROP;

    if (LGFIFO < LGSIZE) begin : g_bad_depth
        $error("fft_frame_unloader: LGFIFO must be >= LGSIZE");
    end

    logic [1:0]        state;
    logic [LGSIZE-1:0] cnt;
    logic              wr_en;
    logic              rd_en;
    logic [1:0]        flags;
    logic [EW-1:0]     rd_data;
    logic [LGFIFO:0]   occ;
    logic              empty;
    logic              room;
    logic              drop_evt;
    logic              load_ok;

    assign room     = (occ <= MAX_OCC);
    assign drop_evt = s.i_ce && (cnt == '0) && s.i_sync && !room;
    assign load_ok  = !s.o_valid || s.i_ready;
    assign rd_en    = load_ok && !empty;

    always_comb begin
        wr_en = 1'b0;
        flags = 2'b00;
        if (s.i_ce) begin
            if (cnt == '0) begin
                if (s.i_sync && room) begin
                    wr_en            = 1'b1;
                    flags[FIRST_BIT] = 1'b1;
                end
            end else if (state == S_STREAM) begin
                wr_en           = 1'b1;
                flags[LAST_BIT] = (cnt == CNT_LAST);
            end
        end
    end

    fft_unload_fifo #(.DW(EW), .LGFIFO(LGFIFO)) u_fifo (
        .clk     (i_clk),
        .reset   (i_reset),
        .wr_en   (wr_en),
        .wr_data ({flags, s.i_sample}),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .occ     (occ),
        .empty   (empty)
    );

    // A zero counter is a frame boundary in every state; only the counter decides framing
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_SEARCH;
            cnt        <= '0;
            o_sync_err <= 1'b0;
            o_drop     <= 1'b0;
        end else if (s.i_ce) begin
            if (cnt == '0) begin
                if (s.i_sync) begin
                    cnt <= LGSIZE'(1);
                    if (room) begin
                        state <= S_STREAM;
                    end else begin
                        state  <= S_DROP;
                        o_drop <= 1'b1;
                    end
                end else begin
                    state <= S_SEARCH;
                end
            end else begin
                if (s.i_sync)
                    o_sync_err <= 1'b1;
                cnt <= cnt + LGSIZE'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s.o_valid <= 1'b0;
            s.o_data  <= '0;
            s.o_first <= 1'b0;
            s.o_last  <= 1'b0;
        end else if (load_ok) begin
            s.o_valid <= !empty;
            if (!empty) begin
                s.o_data  <= rd_data[SW-1:0];
                s.o_first <= rd_data[SW + FIRST_BIT];
                s.o_last  <= rd_data[SW + LAST_BIT];
            end
        end
    end

`ifdef FFT_UNLOAD_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_frame_count <= '0;
            o_drop_count  <= '0;
        end else begin
            if (s.o_valid && s.i_ready && s.o_last && (o_frame_count != '1))
                o_frame_count <= o_frame_count + STATS_W'(1);
            if (drop_evt && (o_drop_count != '1))
                o_drop_count <= o_drop_count + STATS_W'(1);
        end
    end
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif
endmodule

// File: tb/tb_fft_frame_unloader.sv
// tb/tb_fft_frame_unloader.sv - directed self-checking bench for fft_frame_unloader (N=8, depth 16, WIDTH=4)
module tb_fft_frame_unloader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_err;
    logic drop;
`ifdef FFT_UNLOAD_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] drop_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [9:0] beats[$];

    fft_frame_unloader_if #(.WIDTH(4)) bus ();

    fft_frame_unloader #(.LGSIZE(3), .WIDTH(4), .LGFIFO(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .s             (bus.slave),
        .o_sync_err    (sync_err),
        .o_drop        (drop)
`ifdef FFT_UNLOAD_STATS_EN
        ,
        .o_frame_count (frame_count),
        .o_drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_valid && bus.i_ready)
            beats.push_back({bus.o_first, bus.o_last, bus.o_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic sy);
        bus.i_ce     = 1'b1;
        bus.i_sample = d;
        bus.i_sync   = sy;
        @(posedge clk);
        #1;
        bus.i_ce   = 1'b0;
        bus.i_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.i_ce   = 1'b0;
        bus.i_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        beats.delete();
    endtask

    initial begin
        bus.i_ce     = 1'b0;
        bus.i_sample = '0;
        bus.i_sync   = 1'b0;
        bus.i_ready  = 1'b1;

        do_reset();
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_first", bus.o_first, 0);
        chk("rst_last", bus.o_last, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_drop", drop, 0);

        // Nominal: two back-to-back frames
        send(8'd0, 1'b1);
        chk("lat_valid_early", bus.o_valid, 0);
        send(8'd1, 1'b0);
        chk("lat_valid", bus.o_valid, 1);
        chk("lat_data", bus.o_data, 0);
        chk("lat_first", bus.o_first, 1);
        for (int i = 2; i < 16; i++)
            send(8'(i), i == 8);
        idle(4);
        chk("nom_count", beats.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("nom_data", beats[i][7:0], 64'(i));
            chk("nom_first", beats[i][9], 64'((i % 8) == 0));
            chk("nom_last", beats[i][8], 64'((i % 8) == 7));
        end

        // Leading garbage before the first sync
        do_reset();
        for (int i = 0; i < 5; i++)
            send(8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 8; i++)
            send(8'(8'h10 + i), i == 0);
        idle(4);
        chk("garb_count", beats.size(), 8);
        chk("garb_data0", beats[0][7:0], 8'h10);
        chk("garb_first0", beats[0][9], 1);
        chk("garb_data7", beats[7][7:0], 8'h17);
        chk("garb_last7", beats[7][8], 1);

        // Backpressure: two frames fit, third is dropped
        do_reset();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            send(8'(8'h20 + i), (i % 8) == 0);
            if (i == 7) begin
                chk("bp_hold_valid", bus.o_valid, 1);
                chk("bp_hold_data", bus.o_data, 8'h20);
            end
        end
        chk("bp_drop", drop, 1);
        chk("bp_no_beats", beats.size(), 0);
        idle(3);
        chk("bp_still_data", bus.o_data, 8'h20);
        chk("bp_still_first", bus.o_first, 1);
        bus.i_ready = 1'b1;
        idle(25);
        chk("bp_count", beats.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("bp_data", beats[i][7:0], 64'(8'h20 + i));
            chk("bp_first", beats[i][9], 64'((i % 8) == 0));
            chk("bp_last", beats[i][8], 64'((i % 8) == 7));
        end
        chk("bp_empty_valid", bus.o_valid, 0);
`ifdef FFT_UNLOAD_STATS_EN
        chk("stats_frames", frame_count, 2);
        chk("stats_drops", drop_count, 1);
`endif

        // Sync in the middle of a frame is flagged and ignored
        do_reset();
        for (int i = 0; i < 8; i++)
            send(8'(8'h40 + i), (i == 0) || (i == 3));
        send(8'h48, 1'b0);
        idle(4);
        chk("mid_sync_err", sync_err, 1);
        chk("mid_drop", drop, 0);
        chk("mid_count", beats.size(), 8);
        chk("mid_first0", beats[0][9], 1);
        chk("mid_first3", beats[3][9], 0);
        chk("mid_data7", beats[7][7:0], 8'h47);
        chk("mid_last7", beats[7][8], 1);

        // Reset in the middle of a buffered frame
        do_reset();
        bus.i_ready = 1'b0;
        send(8'h50, 1'b1);
        send(8'h51, 1'b0);
        send(8'h52, 1'b1);
        send(8'h53, 1'b0);
        chk("rmid_pre_err", sync_err, 1);
        chk("rmid_pre_valid", bus.o_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rmid_valid", bus.o_valid, 0);
        chk("rmid_sync_err", sync_err, 0);
        chk("rmid_drop", drop, 0);
        chk("rmid_data", bus.o_data, 0);
        beats.delete();
        bus.i_ready = 1'b1;
        send(8'h54, 1'b0);
        send(8'h55, 1'b0);
        for (int i = 0; i < 8; i++)
            send(8'(8'h60 + i), i == 0);
        idle(4);
        chk("rmid_count", beats.size(), 8);
        chk("rmid_data0", beats[0][7:0], 8'h60);
        chk("rmid_first0", beats[0][9], 1);
        chk("rmid_data7", beats[7][7:0], 8'h67);
        chk("rmid_last7", beats[7][8], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
